// File: rtl/sm_accumulate_drain_if.sv
// Purpose: handshake bundle between the term producer, the accumulate/drain block
//          and the activation stage.
// Signals:
//   in_valid/in_ready/in_data/in_last      term stream into the accumulator
//   out_valid/out_ready/out_data/out_sat/out_cnt  saturated sign-magnitude result stream
// Modports: slave = the accumulator itself, master = the environment driving it.
interface sm_accumulate_drain_if #(
  parameter int unsigned DW    = 21,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_sat;
  logic [CNT_W-1:0] out_cnt;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_cnt
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_cnt
  );
endinterface

// File: rtl/sm_accumulate_drain.sv
// Purpose: accumulates a stream of sign-magnitude terms in a wide two's-complement
//          register and, on the term flagged last, drains the total as a saturated
//          sign-magnitude word with its term count.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   sm_accumulate_drain_if.slave: term input stream and result output stream
module sm_accumulate_drain #(
  parameter int unsigned DW    = 21,
  parameter int unsigned ACC_W = 28,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  sm_accumulate_drain_if.slave   bus
);

  localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'((64'd1 << (DW-1)) - 64'd1);

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Sign-magnitude term to two's complement; -0 naturally maps to 0.
  logic [ACC_W-1:0] term_mag;
  logic [ACC_W-1:0] term;
  assign term_mag = ACC_W'(bus.in_data[DW-2:0]);
  assign term     = bus.in_data[DW-1] ? (~term_mag + ACC_W'(1)) : term_mag;

  // Accumulator magnitude and clamp; a negative acc is never zero, so no -0 result.
  logic             acc_neg;
  logic [ACC_W-1:0] acc_abs;
  logic             sat;
  logic [DW-2:0]    mag;
  assign acc_neg = acc_q[ACC_W-1];
  assign acc_abs = acc_neg ? (~acc_q + ACC_W'(1)) : acc_q;
  assign sat     = (acc_abs > MAG_MAX);
  assign mag     = sat ? {(DW-1){1'b1}} : acc_abs[DW-2:0];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_cnt_q   <= out_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    out_cnt_d  = out_cnt_q;

    case (state_q)
      ST_ACC: begin
        if (bus.in_valid && in_ready_q) begin
          acc_d = acc_q + term;
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.in_last) begin
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        out_data_d = {acc_neg, mag};
        out_sat_d  = sat;
        out_cnt_d  = cnt_q;
        acc_d      = '0;
        cnt_d      = '0;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase

    // Handshake flags are registered copies of the state being entered.
    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_HOLD);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_sm_accumulate_drain.sv
// Purpose: self-checking bench for sm_accumulate_drain: directed sums with literal
//          expectations plus a randomized stream checked against an arithmetic model.
module tb_sm_accumulate_drain;
  localparam int unsigned DW    = 21;
  localparam int unsigned CNT_W = 8;
  localparam longint      MAXM  = 64'h0F_FFFF;

  typedef struct {
    logic [DW-1:0]    d;
    logic             s;
    logic [CNT_W-1:0] c;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm_accumulate_drain_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  sm_accumulate_drain #(.DW(DW), .ACC_W(28), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference arithmetic: plain signed integers, then saturate to sign-magnitude.
  function automatic longint sm2int(input logic [DW-1:0] v);
    longint m;
    m = longint'(v[DW-2:0]);
    return v[DW-1] ? -m : m;
  endfunction

  function automatic res_t to_res(input longint s, input int c);
    res_t   r;
    longint m;
    m   = (s < 0) ? -s : s;
    r.s = (m > MAXM);
    if (r.s) m = MAXM;
    r.d = {((s < 0) ? 1'b1 : 1'b0), 20'(m)};
    r.c = CNT_W'(c);
    return r;
  endfunction

  longint m_sum = 0;
  int     m_cnt = 0;
  res_t   exp_q[$];

  // Monitor: predicts results from accepted terms and checks every held result cycle.
  always @(negedge clk) begin
    if (rst) begin
      m_sum = 0;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("model_out_data", bus.out_data, exp_q[0].d);
          chk("model_out_sat", bus.out_sat, exp_q[0].s);
          chk("model_out_cnt", bus.out_cnt, exp_q[0].c);
          chk("in_ready_while_holding", bus.in_ready, 0);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        m_sum += sm2int(bus.in_data);
        m_cnt++;
        if (bus.in_last) begin
          exp_q.push_back(to_res(m_sum, m_cnt));
          m_sum = 0;
          m_cnt = 0;
        end
      end
    end
  end

  // Offer one term until accepted; called and returns just after a rising edge.
  task automatic push(input logic [DW-1:0] d, input logic last);
    int g = 0;
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!ok && g < 200);
    if (!ok) chk("push_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait for a result, hold off `delay` cycles, then accept it.
  task automatic get_result(input int delay, output res_t r);
    int g = 0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (!bus.out_valid) begin
      chk("result_timeout", 0, 1);
      r = '{default: '0};
      @(posedge clk);
      #1;
      return;
    end
    repeat (delay) @(negedge clk);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    r.d = bus.out_data;
    r.s = bus.out_sat;
    r.c = bus.out_cnt;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_res(input string name, input res_t r,
                         input logic [DW-1:0] d, input logic s, input int c);
    chk({name, "_data"}, r.d, d);
    chk({name, "_sat"},  r.s, s);
    chk({name, "_cnt"},  r.c, c);
  endtask

  res_t r;
  int   got;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    chk("rst_out_cnt", bus.out_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic mixed-sign sum and result latency.
    push(21'h000005, 1'b0);
    push(21'h100003, 1'b0);
    push(21'h00000A, 1'b1);
    @(negedge clk);
    chk("latency_conv_out_valid", bus.out_valid, 0);
    chk("latency_conv_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("latency_hold_out_valid", bus.out_valid, 1);
    get_result(0, r);
    chk_res("sum_12", r, 21'h00000C, 1'b0, 3);

    // Cancelling sum and lone negative zero both give +0.
    push(21'h100005, 1'b0);
    push(21'h000005, 1'b1);
    get_result(0, r);
    chk_res("cancel_zero", r, 21'h000000, 1'b0, 2);
    push(21'h100000, 1'b1);
    get_result(0, r);
    chk_res("neg_zero", r, 21'h000000, 1'b0, 1);

    // Saturation boundaries.
    push(21'h0FFFFF, 1'b0);
    push(21'h0FFFFF, 1'b1);
    get_result(0, r);
    chk_res("sat_pos", r, 21'h0FFFFF, 1'b1, 2);
    push(21'h1FFFFF, 1'b0);
    push(21'h1FFFFF, 1'b1);
    get_result(0, r);
    chk_res("sat_neg", r, 21'h1FFFFF, 1'b1, 2);
    push(21'h1FFFFF, 1'b0);
    push(21'h000001, 1'b1);
    get_result(0, r);
    chk_res("near_neg_full", r, 21'h1FFFFE, 1'b0, 2);

    // Backpressure: result held, input ignored, then next sum.
    push(21'h000003, 1'b0);
    push(21'h000004, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 21'h0ABCDE;
    bus.in_last  = 1'b1;
    got = 0;
    @(negedge clk);
    while (!bus.out_valid && got < 20) begin
      @(negedge clk);
      got++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_data_stable", bus.out_data, 21'h000007);
      chk("bp_in_ready_low", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    get_result(0, r);
    chk_res("bp_held", r, 21'h000007, 1'b0, 2);
    push(21'h000007, 1'b0);
    push(21'h100009, 1'b1);
    get_result(2, r);
    chk_res("after_bp", r, 21'h100002, 1'b0, 2);

    // Reset mid-sum discards the partial total.
    push(21'h000001, 1'b0);
    push(21'h000002, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    push(21'h000001, 1'b1);
    get_result(0, r);
    chk_res("after_rst", r, 21'h000001, 1'b0, 1);

    // Randomized stream against the model.
    got = 0;
    fork
      begin
        for (int s = 0; s < 200; s++) begin
          int n;
          n = int'($urandom_range(1, 20));
          for (int k = 0; k < n; k++) begin
            logic [DW-1:0] d;
            case ($urandom_range(0, 3))
              0:       d[DW-2:0] = 20'hFFFFF;
              1:       d[DW-2:0] = 20'($urandom_range(0, 15));
              default: d[DW-2:0] = 20'($urandom);
            endcase
            d[DW-1] = 1'($urandom_range(0, 1));
            push(d, (k == n - 1) ? 1'b1 : 1'b0);
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
          end
        end
      end
      begin
        int g = 0;
        while (got < 200 && g < 30000) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (bus.out_valid && bus.out_ready) got++;
          g++;
        end
      end
    join
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("random_result_count", got, 200);
    chk("model_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
